// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage (if_fetch_unit).
package mips_if_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of IF-stage control, instruction-memory and IF/ID signals.
// FETCH_PERF_EN adds the perf_fetched / perf_bubbles counter outputs.
interface if_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  modport master (
    input  stall, redirect, redirect_target, imem_data,
`ifdef FETCH_PERF_EN
    output perf_fetched, perf_bubbles,
`endif
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_target, imem_data,
`ifdef FETCH_PERF_EN
    input  perf_fetched, perf_bubbles,
`endif
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted
  );
endinterface

// File: rtl/if_fetch_unit_pc_sel.sv
// Combinational fetch-address and next-PC selection for if_fetch_unit.
module if_pc_sel
  import mips_if_pkg::*;
(
  input  fetch_state_e i_state,
  input  logic         i_stall,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_target,
  input  logic         i_halt_hit,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_pc_q,
  output logic [31:0]  o_imem_addr,
  output logic [31:0]  o_pc_nxt,
  output logic [31:0]  o_pc_q_nxt
);

  logic [31:0] w_target;
  assign w_target = align_word(i_redirect_target);

  // Priority: redirect, halt, stall (re-read held word), sequential advance
  always_comb begin
    o_imem_addr = i_pc;
    o_pc_nxt    = i_pc;
    o_pc_q_nxt  = i_pc_q;
    if (i_redirect) begin
      o_imem_addr = w_target;
      o_pc_nxt    = w_target + PC_INC;
      o_pc_q_nxt  = w_target;
    end else begin
      case (i_state)
        HALT: begin
          o_imem_addr = i_pc_q;
        end
        BOOT: begin
          o_pc_nxt   = i_pc + PC_INC;
          o_pc_q_nxt = i_pc;
        end
        RUN: begin
          if (i_stall) begin
            o_imem_addr = i_pc_q;
          end else if (i_halt_hit) begin
            o_imem_addr = i_pc;
          end else begin
            o_pc_nxt   = i_pc + PC_INC;
            o_pc_q_nxt = i_pc;
          end
        end
        default: begin
          o_imem_addr = i_pc;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC; the memory output register doubles as IF/ID.
// Define FETCH_PERF_EN to add fetched/bubble performance counters.
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  if_fetch_unit_if.master  fetch_bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_pc_q;
  logic         r_valid_q;
  logic         w_valid_nxt;
  logic         w_halt_hit;
  logic [31:0]  w_imem_addr;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc_q_nxt;

  assign w_halt_hit = r_valid_q && (fetch_bus.imem_data == HALT_WORD);

  if_pc_sel u_pc_sel (
    .i_state           (r_state),
    .i_stall           (fetch_bus.stall),
    .i_redirect        (fetch_bus.redirect),
    .i_redirect_target (fetch_bus.redirect_target),
    .i_halt_hit        (w_halt_hit),
    .i_pc              (r_pc),
    .i_pc_q            (r_pc_q),
    .o_imem_addr       (w_imem_addr),
    .o_pc_nxt          (w_pc_nxt),
    .o_pc_q_nxt        (w_pc_q_nxt)
  );

  // FSM next state and output-valid update
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid_q;
    if (fetch_bus.redirect) begin
      w_state_nxt = RUN;
      w_valid_nxt = 1'b1;
    end else begin
      case (r_state)
        BOOT: begin
          w_state_nxt = RUN;
          w_valid_nxt = 1'b1;
        end
        RUN: begin
          if (fetch_bus.stall) begin
            w_valid_nxt = r_valid_q;
          end else if (w_halt_hit) begin
            w_state_nxt = HALT;
            w_valid_nxt = 1'b0;
          end else begin
            w_valid_nxt = 1'b1;
          end
        end
        HALT: begin
          w_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = BOOT;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_pc_q    <= RESET_PC;
      r_valid_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pc_q    <= w_pc_q_nxt;
      r_valid_q <= w_valid_nxt;
    end
  end

  assign fetch_bus.imem_addr   = w_imem_addr;
  assign fetch_bus.if_id_valid = r_valid_q;
  assign fetch_bus.if_id_instr = r_valid_q ? fetch_bus.imem_data : NOP_WORD;
  assign fetch_bus.if_id_pc4   = r_pc_q + PC_INC;
  assign fetch_bus.halted      = (r_state == HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  // Consumed instructions and empty non-halted slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'd0;
      r_perf_bubbles <= 32'd0;
    end else begin
      if (r_valid_q && !fetch_bus.stall) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (!r_valid_q && (r_state != HALT)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
    end
  end

  assign fetch_bus.perf_fetched = r_perf_fetched;
  assign fetch_bus.perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan steps, then random
// stall/redirect/reset traffic checked against a behavioural fetch model.
module tb_if_fetch_unit;
  import mips_if_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_unit_if fbus ();

  if_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (fbus)
  );

  // Registered-read instruction memory, word-organised (fetches are always aligned)
  logic [31:0] mem [64];
  always @(posedge clk) fbus.imem_data <= mem[fbus.imem_addr[7:2]];

  int checks   = 0;
  int failures = 0;

  // Reference model: what the IF/ID outputs should show
  logic [31:0] m_cur;      // address of word on the output
  logic [31:0] m_next;     // next sequential address to fetch
  logic        m_valid;
  logic        m_halted;
  logic        m_boot;
  logic [31:0] m_fetched;
  logic [31:0] m_bubbles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  function automatic logic [31:0] exp_addr(input logic st, input logic rd, input logic [31:0] t);
    if (rd) return {t[31:2], 2'b00};
    if (m_halted) return m_cur;
    if (st && !m_boot) return m_cur;
    return m_next;
  endfunction

  task automatic model_reset();
    m_cur = 32'h0; m_next = 32'h0; m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
    m_fetched = 32'd0; m_bubbles = 32'd0;
  endtask

  task automatic model_advance();
    m_cur = m_next; m_next = m_next + 32'd4; m_valid = 1'b1; m_boot = 1'b0;
  endtask

  // One clock: drive inputs, compare everything against the model, take the edge
  task automatic step(input logic rst_v, input logic st, input logic rd, input logic [31:0] t);
    @(negedge clk);
    rst_n = rst_v; fbus.stall = st; fbus.redirect = rd; fbus.redirect_target = t;
    #1;
    chk("imem_addr", fbus.imem_addr, exp_addr(st, rd, t));
    chk("valid", {31'd0, fbus.if_id_valid}, {31'd0, m_valid});
    chk("instr", fbus.if_id_instr, m_valid ? word_at(m_cur) : 32'h0);
    chk("pc4", fbus.if_id_pc4, m_cur + 32'd4);
    chk("halted", {31'd0, fbus.halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_EN
    chk("perf_fetched", fbus.perf_fetched, m_fetched);
    chk("perf_bubbles", fbus.perf_bubbles, m_bubbles);
`endif
    @(posedge clk);
    if (!rst_v) begin
      model_reset();
    end else begin
      if (m_valid && !st) m_fetched = m_fetched + 32'd1;
      if (!m_valid && !m_halted) m_bubbles = m_bubbles + 32'd1;
      if (rd) begin
        m_cur = {t[31:2], 2'b00}; m_next = m_cur + 32'd4;
        m_valid = 1'b1; m_halted = 1'b0; m_boot = 1'b0;
      end else if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_boot) begin
        model_advance();
      end else if (st) begin
        m_boot = 1'b0;
      end else if (m_valid && word_at(m_cur) == 32'hFFFF_FFFF) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else begin
        model_advance();
      end
    end
  endtask

  // Fixed expectations from the test plan, sampled shortly after the edge
  task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] p4, input logic h, input logic [31:0] addr);
    #2;
    chk({tag, "_valid"}, {31'd0, fbus.if_id_valid}, {31'd0, v});
    chk({tag, "_instr"}, fbus.if_id_instr, ins);
    chk({tag, "_pc4"}, fbus.if_id_pc4, p4);
    chk({tag, "_halted"}, {31'd0, fbus.halted}, {31'd0, h});
    chk({tag, "_addr"}, fbus.imem_addr, addr);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'hFFFF_FFFF) mem[i] = 32'h1234_5678;
    end
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    mem[3] = 32'hFFFF_FFFF; mem[4] = 32'h55; mem[63] = 32'hABCD_0FC0;

    rst_n = 1'b0; fbus.stall = 1'b0; fbus.redirect = 1'b0; fbus.redirect_target = 32'h0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state and boot latency
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_out("reset", 1'b0, 32'h0, 32'h4, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("reset_perf_fetched", fbus.perf_fetched, 32'd0);
    chk("reset_perf_bubbles", fbus.perf_bubbles, 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("first", 1'b1, 32'h11, 32'h4, 1'b0, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("second", 1'b1, 32'h22, 32'h8, 1'b0, 32'h8);

    // Stall for 3 cycles holds 0x22 and re-reads address 4
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      expect_out("stall_hold", 1'b1, 32'h22, 32'h8, 1'b0, 32'h4);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("after_stall", 1'b1, 32'h33, 32'hC, 1'b0, 32'hC);

    // Halt word consumed, then fetch stays halted regardless of stall
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("halt_word", 1'b1, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h10);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    expect_out("halted", 1'b0, 32'h0, 32'h10, 1'b1, 32'hC);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    expect_out("halt_exit", 1'b1, 32'h11, 32'h4, 1'b0, 32'h0);

    // Redirect with misaligned target, without and with stall
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h12);
    expect_out("redirect", 1'b1, 32'h55, 32'h14, 1'b0, 32'h10);
    step(1'b1, 1'b0, 1'b1, 32'h4);
    step(1'b1, 1'b1, 1'b1, 32'h12);
    expect_out("redirect_stall", 1'b1, 32'h55, 32'h14, 1'b0, 32'h10);

    // PC wrap at the top of the address space
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    expect_out("wrap_top", 1'b1, 32'hABCD_0FC0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("wrap_zero", 1'b1, 32'h11, 32'h4, 1'b0, 32'h4);

    // Mid-stream reset restarts with one bubble
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_out("mid_reset", 1'b0, 32'h0, 32'h4, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("mid_reset_perf_fetched", fbus.perf_fetched, 32'd0);
    chk("mid_reset_perf_bubbles", fbus.perf_bubbles, 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("restart", 1'b1, 32'h11, 32'h4, 1'b0, 32'h4);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_rd;
      logic [31:0] r_t;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_st  = ($urandom_range(0, 99) < 30);
      r_rd  = ($urandom_range(0, 99) < 12);
      r_t   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      step(r_rst, r_st, r_rd, r_t);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
